// File: rtl/axil_led_timer_slave.sv
// AXI4-Lite LED / period-timer responder with a W1C interrupt status.
// Macro AXIL_SLVERR_EN: when defined, addr[7:4]!=0 answers SLVERR.
//
// Ports:
//   io_systemClk, io_systemResetn : clock, synchronous active-low reset
//   axi_aw*/axi_w*/axi_b*         : AXI4-Lite write address/data/response
//   axi_ar*/axi_r*                : AXI4-Lite read address/data
//   led                           : LED bank drive
//   userInterruptA                : registered level interrupt
//
// Register map (addr[3:2]):
//   0x0 LED, 0x4 PERIOD, 0x8 CTRL{irq_en,blink,run}, 0xC STATUS{pending}
module axil_led_timer_slave #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LED_W      = 8,
  parameter logic [31:0] PERIOD_RST = 32'd50_000_000
) (
  input  logic              io_systemClk,
  input  logic              io_systemResetn,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [1:0]        axi_bresp,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic [LED_W-1:0]  led,
  output logic              userInterruptA
);

  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  // Readies stay low until the first cycle after reset is released.
  logic en_q;

  logic       aw_held_q, aw_held_d;
  logic [5:0] aw_addr_q, aw_addr_d;
  logic       w_held_q, w_held_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0] w_strb_q, w_strb_d;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  logic       rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0] period_q, period_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic       pend_q, pend_d;
  logic [31:0] cnt_q, cnt_d;
  logic       irq_q, irq_d;

  logic        aw_rdy, w_rdy, ar_rdy;
  logic        aw_fire, w_fire, ar_fire;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_go, wr_err, wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;
  logic        rd_err;
  logic [31:0] rd_val;
  logic        wrap;
  logic        unused_bits;

  assign aw_rdy  = en_q & ~aw_held_q & ~bvalid_q;
  assign w_rdy   = en_q & ~w_held_q & ~bvalid_q;
  assign ar_rdy  = en_q & ~rvalid_q;
  assign aw_fire = axi_awvalid & aw_rdy;
  assign w_fire  = axi_wvalid & w_rdy;
  assign ar_fire = axi_arvalid & ar_rdy;

  // A beat arriving this cycle counts as held, so AW+W together
  // commit on the very next edge.
  assign wr_addr = aw_held_q ? aw_addr_q : axi_awaddr[7:2];
  assign wr_data = w_held_q ? w_data_q : axi_wdata;
  assign wr_strb = w_held_q ? w_strb_q : axi_wstrb;
  assign wr_go   = (aw_held_q | aw_fire) & (w_held_q | w_fire);
  assign wr_sel  = wr_addr[1:0];
  assign rd_sel  = axi_araddr[3:2];

`ifdef AXIL_SLVERR_EN
  assign wr_err = |wr_addr[5:2];
  assign rd_err = |axi_araddr[7:4];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign wr_en = wr_go & ~wr_err;

  assign unused_bits = ^{axi_awaddr, axi_araddr, wr_addr};

  // PERIOD of 0 or 1 wraps every cycle.
  assign wrap = ctrl_q[0] &
                ((period_q <= 32'd1) | (cnt_q == period_q - 32'd1));

  always_comb begin
    rd_val = '0;
    unique case (rd_sel)
      2'd0: rd_val[LED_W-1:0] = led_q;
      2'd1: rd_val = period_q;
      2'd2: rd_val[2:0] = ctrl_q;
      2'd3: rd_val[0] = pend_q;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_err ? RESP_ERR : RESP_OK;
    end else begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        aw_addr_d = axi_awaddr[7:2];
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        w_data_d = axi_wdata;
        w_strb_d = axi_wstrb;
      end
      if (bvalid_q && axi_bready) bvalid_d = 1'b0;
    end
  end

  // Read data comes from the pre-edge register values.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err ? 32'd0 : rd_val;
      rresp_d  = rd_err ? RESP_ERR : RESP_OK;
    end else if (rvalid_q && axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Timer effects first, bus writes after, so written
  // LED bytes beat a blink toggle and a wrap beats a W1C.
  always_comb begin
    led_d    = led_q;
    period_d = period_q;
    ctrl_d   = ctrl_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    if (ctrl_q[0]) cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
    if (wrap && ctrl_q[1]) led_d = ~led_q;
    if (wr_en) begin
      unique case (wr_sel)
        2'd0: begin
          for (int i = 0; i < LED_W; i++) begin
            if (wr_strb[i[4:3]]) led_d[i] = wr_data[i];
          end
        end
        2'd1: begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b[1:0]]) period_d[8*b +: 8] = wr_data[8*b +: 8];
          end
          cnt_d = 32'd0;
        end
        2'd2: begin
          if (wr_strb[0]) ctrl_d = wr_data[2:0];
        end
        2'd3: begin
          if (wr_strb[0] && wr_data[0]) pend_d = 1'b0;
        end
      endcase
    end
    if (wrap) pend_d = 1'b1;
  end

  assign irq_d = pend_q & ctrl_q[2];

  always_ff @(posedge io_systemClk) begin
    if (!io_systemResetn) begin
      en_q      <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OK;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OK;
      led_q     <= '0;
      period_q  <= PERIOD_RST;
      ctrl_q    <= '0;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      led_q     <= led_d;
      period_q  <= period_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  assign axi_awready    = aw_rdy;
  assign axi_wready     = w_rdy;
  assign axi_arready    = ar_rdy;
  assign axi_bvalid     = bvalid_q;
  assign axi_bresp      = bresp_q;
  assign axi_rvalid     = rvalid_q;
  assign axi_rdata      = rdata_q;
  assign axi_rresp      = rresp_q;
  assign led            = led_q;
  assign userInterruptA = irq_q;

endmodule

// File: tb/tb_axil_led_timer_slave.sv
// Bench for axil_led_timer_slave: vector table, timer/W1C/reset
// sequences, and random register traffic against a map model.
module tb_axil_led_timer_slave;

  localparam logic [31:0] PRST = 32'd50_000_000;
`ifdef AXIL_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [7:0] led;
  logic irq;

  axil_led_timer_slave dut (
    .io_systemClk   (clk),
    .io_systemResetn(rstn),
    .axi_awvalid    (awvalid),
    .axi_awready    (awready),
    .axi_awaddr     (awaddr),
    .axi_wvalid     (wvalid),
    .axi_wready     (wready),
    .axi_wdata      (wdata),
    .axi_wstrb      (wstrb),
    .axi_bvalid     (bvalid),
    .axi_bready     (bready),
    .axi_bresp      (bresp),
    .axi_arvalid    (arvalid),
    .axi_arready    (arready),
    .axi_araddr     (araddr),
    .axi_rvalid     (rvalid),
    .axi_rready     (rready),
    .axi_rdata      (rdata),
    .axi_rresp      (rresp),
    .led            (led),
    .userInterruptA (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;
  int b_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    logic [31:0] edata;
    logic [1:0]  eresp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit wr, input logic [31:0] a, d,
                      input logic [3:0] s, input int awd, wd,
                      input logic [31:0] ed, input logic [1:0] er,
                      input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.awd = awd; v.wd = wd; v.edata = ed; v.eresp = er; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    repeat (2) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", led, 0);
    check("rst_irq", irq, 0);
    rstn = 1'b1;
  endtask

  task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s,
                           input int awd, wd, output logic [1:0] resp);
    bit aw_done, w_done;
    int n, m;
    aw_done = 0; w_done = 0; n = 0; m = 0;
    while (!(aw_done && w_done) && n < 40) begin
      @(negedge clk);
      awvalid = !aw_done && n >= awd; awaddr = a;
      wvalid = !w_done && n >= wd; wdata = d; wstrb = s;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      n++;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 1;
    while (!bvalid && m < 20) begin
      @(negedge clk);
      m++;
    end
    check("wr_bvalid", bvalid, 1);
    b_cyc = cyc;
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit done;
    int n, m;
    done = 0; n = 0; m = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      arvalid = 1; araddr = a;
      if (arready) done = 1;
      n++;
    end
    @(negedge clk);
    arvalid = 0; rready = 1;
    while (!rvalid && m < 20) begin
      @(negedge clk);
      m++;
    end
    check("rd_rvalid", rvalid, 1);
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [1:0] r;
  logic [31:0] rd, a, d, exp_d;
  logic [3:0] s, hi;
  logic [1:0] idx, lo;
  int e, k, g;
  bit err;
  logic [31:0] m_led, m_per;
  logic [2:0] m_ctrl;
  logic m_pend;

  initial begin
    addv(0, 32'h4, 0, 0, 0, 0, PRST, 0, "rd_period_rst");
    addv(0, 32'h0, 0, 0, 0, 0, 0, 0, "rd_led_rst");
    addv(0, 32'h8, 0, 0, 0, 0, 0, 0, "rd_ctrl_rst");
    addv(0, 32'hC, 0, 0, 0, 0, 0, 0, "rd_stat_rst");
    addv(1, 32'h0, 32'hA5, 4'hF, 0, 0, 0, 0, "wr_led");
    addv(0, 32'h1, 0, 0, 0, 0, 32'hA5, 0, "rd_led_lowaddr");
    addv(1, 32'h4, 32'h12345678, 4'h5, 2, 0, 0, 0, "wr_period_wfirst");
    addv(0, 32'h4, 0, 0, 0, 0, 32'h0234F078, 0, "rd_period_strb");
    addv(1, 32'h8, 32'hFFFFFFF6, 4'h1, 0, 1, 0, 0, "wr_ctrl");
    addv(0, 32'h8, 0, 0, 0, 0, 32'h6, 0, "rd_ctrl");
    addv(1, 32'h8, 32'h0, 4'hF, 0, 0, 0, 0, "wr_ctrl0");
    addv(1, 32'h0, 32'hFFFFFF3C, 4'h1, 0, 0, 0, 0, "wr_led_b0");
    addv(0, 32'h0, 0, 0, 0, 0, 32'h3C, 0, "rd_led_b0");
    addv(0, 32'h10, 0, 0, 0, 0, SLV ? 32'h0 : 32'h3C,
         SLV ? 2'b10 : 2'b00, "rd_0x10");
    addv(1, 32'h14, 32'h99, 4'hF, 0, 0, 0, SLV ? 2'b10 : 2'b00,
         "wr_0x14");
    addv(0, 32'h4, 0, 0, 0, 0, SLV ? 32'h0234F078 : 32'h99, 0,
         "rd_period_alias");
    addv(0, 32'h1C, 0, 0, 0, 0, 0, SLV ? 2'b10 : 2'b00, "rd_0x1c");

    rstn = 1'b0;
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb,
                  tbl[i].awd, tbl[i].wd, r);
        check({tbl[i].name, "_bresp"}, r, tbl[i].eresp);
      end else begin
        axi_read(tbl[i].addr, rd, r);
        check(tbl[i].name, rd, tbl[i].edata);
        check({tbl[i].name, "_rresp"}, r, tbl[i].eresp);
      end
    end
    check("led_pin_tbl", led, 32'h3C);

    // AW leads W by one cycle, then B is back-pressured.
    @(negedge clk);
    awvalid = 1; awaddr = 0;
    check("a_awready", awready, 1);
    @(negedge clk);
    awvalid = 0; wvalid = 1; wdata = 32'hA5; wstrb = 4'hF;
    check("a_wready", wready, 1);
    check("a_bvalid_early", bvalid, 0);
    @(negedge clk);
    wvalid = 0;
    check("a_bvalid", bvalid, 1);
    check("a_bresp", bresp, 0);
    check("a_led", led, 32'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_bvalid_hold", bvalid, 1);
      check("a_awready_low", awready, 0);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("a_bvalid_fall", bvalid, 0);

    // Blink with PERIOD=4.
    axi_write(32'h4, 32'd4, 4'hF, 0, 0, r);
    axi_write(32'h0, 32'h0F, 4'hF, 0, 0, r);
    axi_write(32'h8, 32'h7, 4'hF, 0, 0, r);
    e = b_cyc;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k = cyc - e;
      check("blink_led", led, ((k / 4) % 2) ? 32'hF0 : 32'h0F);
      check("irq_rise", irq, (k >= 5) ? 32'd1 : 32'd0);
    end

    // W1C landing on a wrap edge: set wins.
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (((cyc + 1 - e) % 4) != 0 && g < 10);
    awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 1; wstrb = 1;
    bready = 1;
    @(negedge clk);
    check("w1c_wrap_bvalid", bvalid, 1);
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'hC; rready = 1;
    @(negedge clk);
    arvalid = 0; bready = 0;
    check("w1c_wrap_rvalid", rvalid, 1);
    check("w1c_wrap_pend", rdata, 1);
    check("w1c_wrap_irq", irq, 1);
    @(negedge clk);
    rready = 0;

    // W1C between wraps clears pending; irq drops a cycle later.
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (((cyc + 1 - e) % 4) != 1 && g < 10);
    awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 1; wstrb = 1;
    bready = 1;
    @(negedge clk);
    check("w1c_bvalid", bvalid, 1);
    check("w1c_irq_still", irq, 1);
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'hC; rready = 1;
    @(negedge clk);
    arvalid = 0; bready = 0;
    check("w1c_pend", rdata, 0);
    check("w1c_irq_drop", irq, 0);
    @(negedge clk);
    rready = 0;
    axi_write(32'h8, 32'h0, 4'hF, 0, 0, r);

    // PERIOD 0 and 1 wrap every cycle.
    for (int p = 0; p < 2; p++) begin
      axi_write(32'h4, p, 4'hF, 0, 0, r);
      axi_write(32'h0, 32'h0F, 4'hF, 0, 0, r);
      axi_write(32'h8, 32'h3, 4'hF, 0, 0, r);
      e = b_cyc;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        k = cyc - e;
        check("fast_blink", led, (k % 2) ? 32'hF0 : 32'h0F);
      end
      axi_write(32'h8, 32'h0, 4'hF, 0, 0, r);
    end

    // Read and write of LED in the same cycle.
    axi_write(32'h0, 32'h11, 4'hF, 0, 0, r);
    @(negedge clk);
    awvalid = 1; awaddr = 0; wvalid = 1; wdata = 32'h22; wstrb = 4'hF;
    arvalid = 1; araddr = 0; bready = 1; rready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rw_rvalid", rvalid, 1);
    check("rw_old", rdata, 32'h11);
    check("rw_bvalid", bvalid, 1);
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(32'h0, rd, r);
    check("rw_new", rd, 32'h22);

    // Out-of-range write.
    axi_write(32'h10, 32'hFF, 4'hF, 0, 0, r);
    check("wr_0x10_bresp", r, SLV ? 32'd2 : 32'd0);
    axi_read(32'h0, rd, r);
    check("wr_0x10_led", rd, SLV ? 32'h22 : 32'hFF);

    // Reset with a read and a write address in flight.
    axi_write(32'h0, 32'h5A, 4'hF, 0, 0, r);
    @(negedge clk);
    awvalid = 1; awaddr = 0; arvalid = 1; araddr = 32'h4;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    check("mid_rvalid", rvalid, 1);
    do_reset();
    @(negedge clk);
    wvalid = 1; wdata = 32'hFF; wstrb = 4'hF; bready = 1;
    repeat (4) @(negedge clk);
    check("mid_no_bvalid", bvalid, 0);
    check("mid_led", led, 0);
    wvalid = 0; bready = 0;

    // Random register traffic, timer stopped.
    do_reset();
    m_led = 0; m_per = PRST; m_ctrl = 0; m_pend = 0;
    for (int t = 0; t < 80; t++) begin
      hi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      idx = 2'($urandom_range(0, 3));
      lo = 2'($urandom_range(0, 3));
      a = {24'h0, hi, idx, lo};
      err = SLV && (hi != 0);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        if (idx == 2) d[0] = 1'b0;
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
        check("rnd_bresp", r, err ? 32'd2 : 32'd0);
        if (!err) begin
          case (idx)
            2'd0: m_led = merge(m_led, d, s) & 32'hFF;
            2'd1: m_per = merge(m_per, d, s);
            2'd2: if (s[0]) m_ctrl = d[2:0];
            default: if (s[0] && d[0]) m_pend = 1'b0;
          endcase
        end
      end else begin
        axi_read(a, rd, r);
        case (idx)
          2'd0: exp_d = m_led;
          2'd1: exp_d = m_per;
          2'd2: exp_d = {29'd0, m_ctrl};
          default: exp_d = {31'd0, m_pend};
        endcase
        if (err) exp_d = 0;
        check("rnd_rdata", rd, exp_d);
        check("rnd_rresp", r, err ? 32'd2 : 32'd0);
      end
      check("rnd_led", led, m_led);
      check("rnd_irq", irq, m_pend & m_ctrl[2]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axil_led_timer_slave.md
Name: axil_led_timer_slave

Overview:
- AXI4-Lite responder peripheral on the Sapphire SoC AXI4-Lite master port; drives the board LED bank and the SoC's userInterruptA line.
- Holds a small register file: LED output, blink/timer period, control, and a write-1-to-clear interrupt status.
- A free-running period timer toggles the LEDs (blink mode) and raises the interrupt on each period wrap.

Parameters:
- ADDR_W, 32, AXI address width; only addr[3:2] are decoded, addr[1:0] are ignored.
- LED_W, 8, number of LED outputs (1..32).
- PERIOD_RST, 32'd50_000_000, reset value of the PERIOD register.

Ports:
- io_systemClk  in  1  system clock; all logic is on its rising edge.
- io_systemResetn  in  1  synchronous active-low reset.
- axi_awvalid  in  1  write-address valid.
- axi_awready  out  1  write-address ready.
- axi_awaddr  in  ADDR_W  write address.
- axi_wvalid  in  1  write-data valid.
- axi_wready  out  1  write-data ready.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte strobes.
- axi_bvalid  out  1  write-response valid.
- axi_bready  in  1  write-response ready.
- axi_bresp  out  2  write response.
- axi_arvalid  in  1  read-address valid.
- axi_arready  out  1  read-address ready.
- axi_araddr  in  ADDR_W  read address.
- axi_rvalid  out  1  read-data valid.
- axi_rready  in  1  read-data ready.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- led  out  LED_W  LED drive.
- userInterruptA  out  1  level interrupt to the SoC.

Behaviour:
- Register map:
  - 0x0 LED: RW, LED_W bits.
  - 0x4 PERIOD: RW, 32 bits.
  - 0x8 CTRL: bit0 run, bit1 blink, bit2 irq_en.
  - 0xC STATUS: bit0 pending, write-1-to-clear; other bits read 0.
- Reset values (applied while io_systemResetn=0 at a clock edge):
  - All AXI valid/ready outputs 0; bresp/rresp 0; rdata 0.
  - LED=0, PERIOD=PERIOD_RST, CTRL=0, pending=0, timer count=0.
- Write channel:
  - AW and W are captured independently into holding registers.
  - axi_awready=1 when no address is held and bvalid=0; axi_wready=1 when no data is held and bvalid=0.
  - The cycle after both are held, the register is updated (per byte lane, using wstrb) and bvalid=1; both holding registers are freed.
  - bvalid and bresp stay stable until bready; bvalid falls on the cycle after the bvalid&bready handshake.
  - AW and W arriving in the same cycle: register updated and bvalid=1 on the following edge (1-cycle latency).
- Read channel:
  - axi_arready = ~rvalid.
  - On an accepted AR, rvalid=1 on the next edge, with rdata sampled from the register value at the acceptance cycle.
  - rdata/rresp are held stable until rready.
  - No new AR is accepted while rvalid=1.
- Reads and writes proceed concurrently. A read of a register written in the same cycle returns the old value.
- Timer (advances only when CTRL.run=1):
  - When count == PERIOD-1: count wraps to 0, pending is set, and LED is inverted if blink=1; otherwise count increments.
  - PERIOD=0 or 1 means a wrap every cycle.
  - Clearing run freezes count (it does not reset it).
  - A write to PERIOD resets count to 0.
- Pending set and W1C in the same cycle: set wins, so pending stays 1.
- LED write and blink toggle in the same cycle: the written value wins.
- userInterruptA = pending & CTRL.irq_en, registered output (1-cycle delay after pending/irq_en change).
- Reset asserted mid-transaction: all channels abort, outputs return to reset values, and no response is issued.

Optional Feature:
- Macro AXIL_SLVERR_EN. Governs accesses with araddr/awaddr above offset 0xF in the low byte (i.e. addr[7:4]≠0).
  - Defined: such accesses return resp=2'b10 (SLVERR), read data 0, and writes have no effect.
  - Undefined: these addresses alias onto the 0x0–0xC registers, and resp is always 2'b00 (OKAY).

Test Plan:
- Reset, then read 0x4 → rdata=PERIOD_RST, rresp=0; read 0x0 → 0; led=0; userInterruptA=0.
- Write 0x0=0xA5 with AW one cycle before W → bvalid one cycle after W accepted, bresp=0; led=8'hA5. Holding bready=0 for 5 cycles keeps bvalid=1 and awready=0.
- PERIOD=4, CTRL=0x7, LED=0x0F → led toggles 0x0F↔0xF0 every 4 cycles; pending=1; userInterruptA=1 one cycle after the first wrap.
- W1C 0xC=0x1 on the exact cycle of a wrap → pending stays 1. W1C on a non-wrap cycle → pending=0, and userInterruptA drops the next cycle.
- Read and write issued in the same cycle to 0x0 (old=0x11, new=0x22) → rdata=0x11; a subsequent read returns 0x22.
- AXIL_SLVERR_EN defined: read 0x10 → rresp=2, rdata=0; write 0x10 → bresp=2, no register changes. Undefined: read 0x10 → LED value, rresp=0.
